// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction memory
// one word per cycle into a small prefetch FIFO and hands {PC, instruction} pairs to decode.
module imem_fetch_controller #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMEM_WORDS = 396,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        OutOfRange
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] pc_mem_q  [FIFO_DEPTH];
  logic [31:0] ins_mem_q [FIFO_DEPTH];

  logic [31:0] redirect_pc;
  logic [31:0] pc_plus4;
  logic        fifo_full;
  logic        head_valid;
  logic        push;
  logic        pop;

  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;
  assign pc_plus4    = pc_q + 32'd4;
  assign fifo_full   = (count_q == FULL_COUNT);
  assign head_valid  = (count_q != '0);

  // Redirect flushes the FIFO, so neither a pop nor a push may land in that cycle.
  assign pop  = head_valid && InstrReady && !Redirect;
  assign push = (state_q == FETCH) && (!fifo_full || pop) && !Redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (push) begin
      pc_d = pc_plus4;
    end
    case (state_q)
      IDLE:    if (Enable) state_d = FETCH;
      FETCH: begin
        if (push && (pc_plus4 >= PC_LIMIT)) begin
          state_d = HALT;
        end else if (!Enable) begin
          state_d = IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (Redirect) begin
      pc_d = redirect_pc;
      if (redirect_pc >= PC_LIMIT) begin
        state_d = HALT;
      end else begin
        state_d = Enable ? FETCH : IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (Redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: every read is gated by head_valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= pc_q;
      ins_mem_q[wr_ptr_q] <= IMemInstruction;
    end
  end

  assign IMemAddress = pc_q;
  assign InstrValid  = head_valid;
  assign InstrOut    = head_valid ? ins_mem_q[rd_ptr_q] : 32'h0;
  assign InstrPC     = head_valid ? pc_mem_q[rd_ptr_q]  : 32'h0;
  assign OutOfRange  = (state_q == HALT);

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller: memory word at byte address A is {16'hC0DE, A[15:0]}.
module tb_imem_fetch_controller;

  logic        Clk;
  logic        Reset;
  logic        Enable;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        OutOfRange;

  int n_assert = 0;
  int n_fail   = 0;

  imem_fetch_controller #(
    .FIFO_DEPTH(4),
    .IMEM_WORDS(396),
    .RESET_PC  (32'h0)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (Enable),
    .IMemAddress    (IMemAddress),
    .IMemInstruction(IMemInstruction),
    .InstrValid     (InstrValid),
    .InstrReady     (InstrReady),
    .InstrOut       (InstrOut),
    .InstrPC        (InstrPC),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .OutOfRange     (OutOfRange)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign IMemInstruction = {16'hC0DE, IMemAddress[15:0]};

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    bit          seen_last;

    Reset      = 1'b0;
    Enable     = 1'b0;
    InstrReady = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(InstrValid), 32'h0);
    chk("rst_addr",  IMemAddress,     32'h0);
    chk("rst_out",   InstrOut,        32'h0);
    chk("rst_pc",    InstrPC,         32'h0);
    chk("rst_oor",   32'(OutOfRange), 32'h0);

    // Streaming with decode always ready: two-edge latency, then one per cycle.
    Reset      = 1'b1;
    Enable     = 1'b1;
    InstrReady = 1'b1;
    step();
    chk("lat_valid0", 32'(InstrValid), 32'h0);
    chk("lat_addr0",  IMemAddress,     32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("str_valid", 32'(InstrValid), 32'h1);
      chk("str_pc",    InstrPC,         32'(i * 4));
      chk("str_out",   InstrOut,        mem_word(32'(i * 4)));
    end

    // Asynchronous reset mid-stream, observed between clock edges.
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_valid", 32'(InstrValid), 32'h0);
    chk("arst_addr",  IMemAddress,     32'h0);
    chk("arst_pc",    InstrPC,         32'h0);
    chk("arst_out",   InstrOut,        32'h0);
    chk("arst_oor",   32'(OutOfRange), 32'h0);
    step();

    // Back-pressure: four entries fill, the address sticks at 0x10.
    Reset      = 1'b1;
    Enable     = 1'b1;
    InstrReady = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("full_addr",  IMemAddress,     32'h10);
    chk("full_valid", 32'(InstrValid), 32'h1);
    chk("full_head",  InstrPC,         32'h0);
    InstrReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("drain_pc",   InstrPC,     32'(i * 4));
      chk("drain_addr", IMemAddress, 32'h10 + 32'(i * 4));
    end

    // Redirect on a full FIFO while decode is ready: head is flushed, not consumed.
    Reset = 1'b0;
    step();
    Reset      = 1'b1;
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rd_full_addr", IMemAddress, 32'h10);
    Redirect   = 1'b1;
    RedirectPC = 32'h43;
    InstrReady = 1'b1;
    step();
    Redirect = 1'b0;
    chk("rd_flush_valid", 32'(InstrValid), 32'h0);
    chk("rd_flush_addr",  IMemAddress,     32'h40);
    step();
    chk("rd_first_pc",  InstrPC,  32'h40);
    chk("rd_first_out", InstrOut, 32'hC0DE0040);
    step();
    chk("rd_second_pc", InstrPC, 32'h44);

    // Run off the end of memory from PC 0.
    Redirect   = 1'b1;
    RedirectPC = 32'h0;
    step();
    Redirect  = 1'b0;
    exp_pc    = 32'h0;
    seen_last = 1'b0;
    for (int i = 0; i < 600 && !seen_last; i++) begin
      step();
      if (InstrValid) begin
        chk("run_pc", InstrPC, exp_pc);
        if (InstrPC == 32'h62C) seen_last = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
    end
    chk("run_reached_end", 32'(seen_last), 32'h1);
    chk("end_oor",  32'(OutOfRange), 32'h1);
    chk("end_addr", IMemAddress,     32'h630);
    step();
    chk("halt_drained", 32'(InstrValid), 32'h0);
    step();
    step();
    chk("halt_stays_empty", 32'(InstrValid), 32'h0);
    chk("halt_oor",         32'(OutOfRange), 32'h1);
    Redirect   = 1'b1;
    RedirectPC = 32'h8;
    step();
    Redirect = 1'b0;
    chk("resume_oor",  32'(OutOfRange), 32'h0);
    chk("resume_addr", IMemAddress,     32'h8);
    step();
    chk("resume_pc",  InstrPC,  32'h8);
    chk("resume_out", InstrOut, 32'hC0DE0008);

    // Out-of-range redirect: HALT, Enable toggling does nothing.
    Redirect   = 1'b1;
    RedirectPC = 32'h700;
    step();
    Redirect = 1'b0;
    chk("oor_flag",  32'(OutOfRange), 32'h1);
    chk("oor_valid", 32'(InstrValid), 32'h0);
    chk("oor_addr",  IMemAddress,     32'h700);
    Enable = 1'b0;
    step();
    Enable = 1'b1;
    step();
    step();
    chk("oor_toggle_flag",  32'(OutOfRange), 32'h1);
    chk("oor_toggle_valid", 32'(InstrValid), 32'h0);
    chk("oor_toggle_addr",  IMemAddress,     32'h700);
    Redirect   = 1'b1;
    RedirectPC = 32'h20;
    step();
    Redirect = 1'b0;
    chk("exit_oor", 32'(OutOfRange), 32'h0);
    step();
    chk("exit_pc", InstrPC, 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
